// File: rtl/reprodutor_pkg.sv
// Shared encodings and default widths for the song RAM and the playback sequencer.
package reprodutor_pkg;

   localparam int NOTA_W_DEF  = 4;
   localparam int TEMPO_W_DEF = 4;

   localparam logic [3:0] NOTA_PAUSA_DEF = 4'hF;

   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] BUSCA   = 3'd1;
   localparam logic [2:0] CARREGA = 3'd2;
   localparam logic [2:0] TOCA    = 3'd3;
   localparam logic [2:0] PAUSADO = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

endpackage

// File: rtl/contador_duracao.sv
// Loadable note-duration down-counter, decremented once per enabled metronome tick.
module contador_duracao
   import reprodutor_pkg::*;
#(
   parameter int TEMPO_W = TEMPO_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               carrega,
   input  logic               habilita,
   input  logic [TEMPO_W-1:0] valor,
   output logic [TEMPO_W-1:0] contagem,
   output logic               zero
);

   logic [TEMPO_W-1:0] contagem_r;

   // Load has priority over decrement; the count parks at zero instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         contagem_r <= {TEMPO_W{1'b0}};
      end else if (carrega) begin
         contagem_r <= valor;
      end else if (habilita && (contagem_r != {TEMPO_W{1'b0}})) begin
         contagem_r <= contagem_r - TEMPO_W'(1);
      end else begin
         contagem_r <= contagem_r;
      end
   end

   assign contagem = contagem_r;
   assign zero     = (contagem_r == {TEMPO_W{1'b0}});

endmodule

// File: rtl/reprodutor_musica.sv
// Playback sequencer: walks the song RAM from address 0 and plays each note for its tick count.
// Optional macro REPRODUTOR_LOOP_EN: restart from address 0 after the end-of-song pulse.
module reprodutor_musica
   import reprodutor_pkg::*;
#(
   parameter int                NUM_NOTAS  = 256,
   parameter int                NOTA_W     = NOTA_W_DEF,
   parameter int                TEMPO_W    = TEMPO_W_DEF,
   parameter logic [NOTA_W-1:0] NOTA_PAUSA = NOTA_W'(NOTA_PAUSA_DEF),
   localparam int               ADDR_W     = $clog2(NUM_NOTAS)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               inicia,
   input  logic               pausa,
   input  logic               tick,
   input  logic [NOTA_W-1:0]  mem_nota,
   input  logic [TEMPO_W-1:0] mem_tempo,
   input  logic               mem_fim,
   output logic [ADDR_W-1:0]  addr,
   output logic [NOTA_W-1:0]  nota,
   output logic               toca,
   output logic               tocando,
   output logic               fim,
   output logic [2:0]         db_estado
);

   localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(NUM_NOTAS - 1);

   logic [2:0]         estado_r, estado_s;
   logic [ADDR_W-1:0]  addr_r, addr_s;
   logic [NOTA_W-1:0]  nota_r, nota_s;
   logic               toca_r, toca_s;
   logic               tocando_r, tocando_s;
   logic               fim_r;
   logic               carrega_s, habilita_s, fim_nota_s;
   logic [TEMPO_W-1:0] contagem_s;
   logic               zero_s;

   assign habilita_s = (estado_r == TOCA) && tick && !pausa && !inicia;
   // An empty counter while playing is treated as an ended note so the FSM can never stall.
   assign fim_nota_s = (estado_r == TOCA) &&
                       ((tick && (contagem_s == TEMPO_W'(1))) || zero_s);

   contador_duracao #(.TEMPO_W(TEMPO_W)) u_contador (
      .clock    (clock),
      .reset    (reset),
      .carrega  (carrega_s),
      .habilita (habilita_s),
      .valor    (mem_tempo),
      .contagem (contagem_s),
      .zero     (zero_s)
   );

   // Next-state and next-output decode; a restart request overrides every state but OCIOSO.
   always_comb begin
      estado_s  = estado_r;
      addr_s    = addr_r;
      nota_s    = nota_r;
      toca_s    = toca_r;
      carrega_s = 1'b0;
      if (inicia && (estado_r != OCIOSO)) begin
         estado_s = BUSCA;
         addr_s   = {ADDR_W{1'b0}};
         toca_s   = 1'b0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               toca_s = 1'b0;
               if (inicia) begin
                  estado_s = BUSCA;
                  addr_s   = {ADDR_W{1'b0}};
               end else begin
                  estado_s = OCIOSO;
               end
            end
            BUSCA: begin
               estado_s = CARREGA;
            end
            CARREGA: begin
               if (mem_fim) begin
                  estado_s = FIM;
               end else if (mem_tempo == {TEMPO_W{1'b0}}) begin
                  if (addr_r == ULTIMO) begin
                     estado_s = FIM;
                  end else begin
                     addr_s   = addr_r + ADDR_W'(1);
                     estado_s = BUSCA;
                  end
               end else begin
                  nota_s    = mem_nota;
                  toca_s    = (mem_nota != NOTA_PAUSA);
                  carrega_s = 1'b1;
                  estado_s  = TOCA;
               end
            end
            TOCA: begin
               if (pausa) begin
                  estado_s = PAUSADO;
                  toca_s   = 1'b0;
               end else if (fim_nota_s) begin
                  toca_s = 1'b0;
                  if (addr_r == ULTIMO) begin
                     estado_s = FIM;
                  end else begin
                     addr_s   = addr_r + ADDR_W'(1);
                     estado_s = BUSCA;
                  end
               end else begin
                  estado_s = TOCA;
               end
            end
            PAUSADO: begin
               if (pausa) begin
                  toca_s = 1'b0;
               end else begin
                  estado_s = TOCA;
                  toca_s   = (nota_r != NOTA_PAUSA);
               end
            end
            FIM: begin
               toca_s = 1'b0;
`ifdef REPRODUTOR_LOOP_EN
               estado_s = BUSCA;
               addr_s   = {ADDR_W{1'b0}};
`else
               estado_s = OCIOSO;
`endif
            end
            default: begin
               estado_s = OCIOSO;
               addr_s   = {ADDR_W{1'b0}};
               toca_s   = 1'b0;
            end
         endcase
      end
`ifdef REPRODUTOR_LOOP_EN
      tocando_s = (estado_s != OCIOSO);
`else
      tocando_s = (estado_s != OCIOSO) && (estado_s != FIM);
`endif
   end

   // State and output registers; every output is taken straight from a flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r  <= OCIOSO;
         addr_r    <= {ADDR_W{1'b0}};
         nota_r    <= {NOTA_W{1'b0}};
         toca_r    <= 1'b0;
         tocando_r <= 1'b0;
         fim_r     <= 1'b0;
      end else begin
         estado_r  <= estado_s;
         addr_r    <= addr_s;
         nota_r    <= nota_s;
         toca_r    <= toca_s;
         tocando_r <= tocando_s;
         fim_r     <= (estado_s == FIM);
      end
   end

   assign addr      = addr_r;
   assign nota      = nota_r;
   assign toca      = toca_r;
   assign tocando   = tocando_r;
   assign fim       = fim_r;
   assign db_estado = estado_r;

endmodule

// File: tb/tb_reprodutor_musica.sv
// Directed bench for reprodutor_musica: a timeline model of the song predicts every output per cycle.
module tb_reprodutor_musica;

   localparam int MAXC = 160;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset = 1'b1, inicia = 1'b0, pausa = 1'b0, tick = 1'b0;
   logic [3:0] mem_nota_a = 4'h0, mem_tempo_a = 4'h0, mem_nota_b = 4'h0, mem_tempo_b = 4'h0;
   logic       mem_fim_a = 1'b0, mem_fim_b = 1'b0;
   logic [7:0] addr_a;
   logic [1:0] addr_b;
   logic [3:0] nota_a, nota_b;
   logic       toca_a, toca_b, tocando_a, tocando_b, fim_a, fim_b;
   logic [2:0] est_a, est_b;

   reprodutor_musica #(.NUM_NOTAS(256)) dut_a (
      .clock(clock), .reset(reset), .inicia(inicia), .pausa(pausa), .tick(tick),
      .mem_nota(mem_nota_a), .mem_tempo(mem_tempo_a), .mem_fim(mem_fim_a),
      .addr(addr_a), .nota(nota_a), .toca(toca_a), .tocando(tocando_a),
      .fim(fim_a), .db_estado(est_a)
   );

   reprodutor_musica #(.NUM_NOTAS(4)) dut_b (
      .clock(clock), .reset(reset), .inicia(inicia), .pausa(pausa), .tick(tick),
      .mem_nota(mem_nota_b), .mem_tempo(mem_tempo_b), .mem_fim(mem_fim_b),
      .addr(addr_b), .nota(nota_b), .toca(toca_b), .tocando(tocando_b),
      .fim(fim_b), .db_estado(est_b)
   );

   // Song RAM shared by both instances, synchronous read
   logic [3:0] ram_nota [256];
   logic [3:0] ram_tempo[256];
   logic       ram_fim  [256];

   always @(posedge clock) begin
      mem_nota_a  <= ram_nota[addr_a];
      mem_tempo_a <= ram_tempo[addr_a];
      mem_fim_a   <= ram_fim[addr_a];
      mem_nota_b  <= ram_nota[{6'd0, addr_b}];
      mem_tempo_b <= ram_tempo[{6'd0, addr_b}];
      mem_fim_b   <= ram_fim[{6'd0, addr_b}];
   end

   logic reset_v[MAXC], inicia_v[MAXC], pausa_v[MAXC], tick_v[MAXC];
   logic [3:0] nota_e[MAXC];
   int         addr_e[MAXC];
   logic       toca_e[MAXC], tocando_e[MAXC], fim_e[MAXC];

   typedef struct {
      int         e;
      logic [3:0] nota;
      int         addr;
      logic       toca;
      logic       fim;
      logic [2:0] st;
   } lit_t;
   lit_t lits[$];

   int   checks = 0, errors = 0, idx = 0, last = 255;
   logic sel = 1'b0, chk_en = 1'b0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endfunction

   function automatic void put(int i, logic [3:0] n, int a, logic t, logic tg, logic f);
      if (i < MAXC) begin
         nota_e[i] = n; addr_e[i] = a; toca_e[i] = t; tocando_e[i] = tg; fim_e[i] = f;
      end
   endfunction

   function automatic void idle(int from, logic [3:0] n, int a);
      for (int i = from; i < MAXC; i++) put(i, n, a, 1'b0, 1'b0, 1'b0);
   endfunction

   // Timeline of one playback started by inicia sampled at edge s
   function automatic void play(int s);
      int a, f, e, left, p;
      logic [3:0] n;
      logic aud, done, fin;
      n = nota_e[s-1]; a = 0; f = s + 2; done = 1'b0;
      put(s, n, 0, 1'b0, 1'b1, 1'b0);
      put(s + 1, n, 0, 1'b0, 1'b1, 1'b0);
      while (!done && f < MAXC) begin
         fin = 1'b0; p = f;
         if (ram_fim[a] || (ram_tempo[a] == 4'd0 && a == last)) begin
            fin = 1'b1;
         end else if (ram_tempo[a] == 4'd0) begin
            a++;
            put(f, n, a, 1'b0, 1'b1, 1'b0);
            put(f + 1, n, a, 1'b0, 1'b1, 1'b0);
            f += 2;
         end else begin
            n = ram_nota[a]; aud = (n != 4'hF); left = int'(ram_tempo[a]);
            put(f, n, a, aud, 1'b1, 1'b0);
            e = f + 1;
            while (e < MAXC) begin
               if (tick_v[e] && !pausa_v[e] && !((e - 1 > f) && pausa_v[e-1])) left--;
               if (left == 0) break;
               put(e, n, a, aud && !pausa_v[e], 1'b1, 1'b0);
               e++;
            end
            if (e >= MAXC) begin
               done = 1'b1;
            end else if (a == last) begin
               fin = 1'b1; p = e;
            end else begin
               a++;
               put(e, n, a, 1'b0, 1'b1, 1'b0);
               put(e + 1, n, a, 1'b0, 1'b1, 1'b0);
               f = e + 2;
            end
         end
         if (fin) begin
`ifdef REPRODUTOR_LOOP_EN
            put(p, n, a, 1'b0, 1'b1, 1'b1);
            a = 0;
            put(p + 1, n, 0, 1'b0, 1'b1, 1'b0);
            put(p + 2, n, 0, 1'b0, 1'b1, 1'b0);
            f = p + 3;
`else
            put(p, n, a, 1'b0, 1'b0, 1'b1);
            idle(p + 1, n, a);
            done = 1'b1;
`endif
         end
      end
   endfunction

   function automatic void build(int len);
      for (int e = 0; e < len; e++) begin
         if (reset_v[e]) idle(e, 4'h0, 0);
         else if (inicia_v[e]) play(e);
      end
   endfunction

   // Compare process: every cycle against the model, plus literal pins
   always @(posedge clock) begin
      if (chk_en) begin
         #1;
         chk("toca",    int'(sel ? toca_b    : toca_a),    int'(toca_e[idx]));
         chk("nota",    int'(sel ? nota_b    : nota_a),    int'(nota_e[idx]));
         chk("addr",    sel ? int'(addr_b) : int'(addr_a), addr_e[idx]);
         chk("tocando", int'(sel ? tocando_b : tocando_a), int'(tocando_e[idx]));
         chk("fim",     int'(sel ? fim_b     : fim_a),     int'(fim_e[idx]));
         foreach (lits[i]) begin
            if (lits[i].e == idx) begin
               chk("lit_nota",  int'(sel ? nota_b : nota_a), int'(lits[i].nota));
               chk("lit_addr",  sel ? int'(addr_b) : int'(addr_a), lits[i].addr);
               chk("lit_toca",  int'(sel ? toca_b : toca_a), int'(lits[i].toca));
               chk("lit_fim",   int'(sel ? fim_b : fim_a),   int'(lits[i].fim));
               chk("lit_estado", int'(sel ? est_b : est_a),  int'(lits[i].st));
            end
         end
      end
   end

   task automatic clear(input logic use_b);
      for (int i = 0; i < MAXC; i++) begin
         reset_v[i] = 1'b0; inicia_v[i] = 1'b0; pausa_v[i] = 1'b0; tick_v[i] = 1'b0;
      end
      for (int i = 0; i < 256; i++) begin
         ram_nota[i] = 4'h0; ram_tempo[i] = 4'd0; ram_fim[i] = 1'b1;
      end
      for (int e = 10; e < MAXC; e += 10) tick_v[e] = 1'b1;
      reset_v[0] = 1'b1; reset_v[1] = 1'b1; inicia_v[5] = 1'b1;
      lits.delete();
      sel  = use_b;
      last = use_b ? 3 : 255;
   endtask

   task automatic song(input int i, input logic [3:0] n, input logic [3:0] t);
      ram_nota[i] = n; ram_tempo[i] = t; ram_fim[i] = 1'b0;
   endtask

   task automatic lit(input int e, input logic [3:0] n, input int a, input logic t,
                      input logic f, input logic [2:0] st);
      lit_t l;
      l.e = e; l.nota = n; l.addr = a; l.toca = t; l.fim = f; l.st = st;
      lits.push_back(l);
   endtask

   task automatic run(input int len);
      build(len);
      for (int e = 0; e < len; e++) begin
         @(negedge clock);
         idx = e; reset = reset_v[e]; inicia = inicia_v[e];
         pausa = pausa_v[e]; tick = tick_v[e]; chk_en = 1'b1;
      end
      @(negedge clock);
      chk_en = 1'b0; reset = 1'b0; inicia = 1'b0; pausa = 1'b0; tick = 1'b0;
   endtask

   initial begin
      // Two notes then the end marker
      clear(1'b0);
      song(0, 4'd3, 4'd2); song(1, 4'd5, 4'd1);
      lit(1, 4'd0, 0, 1'b0, 1'b0, 3'd0);
      lit(6, 4'd0, 0, 1'b0, 1'b0, 3'd2);
      lit(7, 4'd3, 0, 1'b1, 1'b0, 3'd3);
      lit(21, 4'd3, 1, 1'b0, 1'b0, 3'd2);
      lit(22, 4'd5, 1, 1'b1, 1'b0, 3'd3);
      lit(32, 4'd5, 2, 1'b0, 1'b1, 3'd5);
      lit(34, 4'd5, 2, 1'b0, 1'b0, 3'd0);
      run(50);

      // Rest entry first
      clear(1'b0);
      song(0, 4'hF, 4'd3); song(1, 4'd7, 4'd1);
      lit(7, 4'hF, 0, 1'b0, 1'b0, 3'd3);
      lit(29, 4'hF, 0, 1'b0, 1'b0, 3'd3);
      lit(32, 4'd7, 1, 1'b1, 1'b0, 3'd3);
      run(60);

      // Zero-length entry skipped
      clear(1'b0);
      song(0, 4'd2, 4'd0); song(1, 4'd6, 4'd1);
      lit(8, 4'd0, 1, 1'b0, 1'b0, 3'd2);
      lit(9, 4'd6, 1, 1'b1, 1'b0, 3'd3);
      run(40);

      // Pause after the second tick of a three-tick note
      clear(1'b0);
      song(0, 4'd9, 4'd3);
      for (int e = 23; e < 48; e++) pausa_v[e] = 1'b1;
      lit(22, 4'd9, 0, 1'b1, 1'b0, 3'd3);
      lit(23, 4'd9, 0, 1'b0, 1'b0, 3'd4);
      lit(47, 4'd9, 0, 1'b0, 1'b0, 3'd4);
      lit(48, 4'd9, 0, 1'b1, 1'b0, 3'd3);
      lit(50, 4'd9, 1, 1'b0, 1'b0, 3'd1);
      lit(52, 4'd9, 1, 1'b0, 1'b1, 3'd5);
      run(70);

      // Restart mid-song, then a restart coinciding with a tick
      clear(1'b0);
      for (int i = 0; i < 6; i++) song(i, 4'(i + 1), 4'd1);
      inicia_v[45] = 1'b1; inicia_v[60] = 1'b1;
      lit(44, 4'd5, 4, 1'b1, 1'b0, 3'd3);
      lit(45, 4'd5, 0, 1'b0, 1'b0, 3'd1);
      lit(47, 4'd1, 0, 1'b1, 1'b0, 3'd3);
      lit(60, 4'd2, 0, 1'b0, 1'b0, 3'd1);
      run(140);

      // Four-entry RAM without an end marker
      clear(1'b1);
      for (int i = 0; i < 4; i++) song(i, 4'(i + 8), 4'd1);
      lit(32, 4'd11, 3, 1'b1, 1'b0, 3'd3);
      lit(40, 4'd11, 3, 1'b0, 1'b1, 3'd5);
`ifdef REPRODUTOR_LOOP_EN
      lit(41, 4'd11, 0, 1'b0, 1'b0, 3'd1);
`else
      lit(45, 4'd11, 3, 1'b0, 1'b0, 3'd0);
`endif
      run(60);

      // Reset mid-song, then a fresh start
      clear(1'b0);
      song(0, 4'd3, 4'd2); song(1, 4'd5, 4'd1);
      reset_v[25] = 1'b1; inicia_v[40] = 1'b1;
      lit(24, 4'd5, 1, 1'b1, 1'b0, 3'd3);
      lit(25, 4'd0, 0, 1'b0, 1'b0, 3'd0);
      lit(42, 4'd3, 0, 1'b1, 1'b0, 3'd3);
      lit(72, 4'd5, 2, 1'b0, 1'b1, 3'd5);
      run(90);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
